calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Front-end controller for the calculator datapath.
- Sequences operand A entry, operator entry and operand B entry from the switch bank using a single Enter pushbutton.
- Issues the operation to the variable-latency arithmetic/logic unit over a start/done handshake, then holds the result or an error for the display decoders.
- Sits between the board switches/keys and the ALU; the seven-segment decoders consume its registered outputs.

Parameters:
- OPW, 4, operand width in bits.
- TIMEOUT, 255, maximum cycles spent in WAIT before forcing error (range 1..255).

Ports:
- clk  input  1  system clock.
- ac  input  1  asynchronous active-high reset (all-clear).
- sw_val  input  OPW  operand switches.
- sw_op  input  3  operator switches: 1 add, 2 mul, 3 div, 4 logical AND, 5 logical OR.
- btn_enter  input  1  Enter pushbutton, active-low, asynchronous to clk.
- alu_start  output  1  one-cycle request pulse to ALU.
- alu_opa  output  OPW  ALU operand A; equals opa_q.
- alu_opb  output  OPW  ALU operand B; equals opb_q.
- alu_op  output  3  ALU opcode; equals op_q.
- alu_done  input  1  one-cycle completion pulse from ALU.
- alu_result  input  2*OPW  ALU result, valid with alu_done.
- alu_err  input  1  ALU error flag, valid with alu_done.
- opa_q  output  OPW  captured operand A.
- opb_q  output  OPW  captured operand B.
- op_q  output  3  captured opcode.
- result_q  output  2*OPW  registered result.
- result_valid  output  1  result_q holds a completed result.
- err_q  output  1  error indication; display shows "Err".
- phase  output  3  current state encoding, for an entry-step LED.
- busy  output  1  high in ISSUE and WAIT.

Behaviour:
- Reset (ac=1, asynchronous):
  - state ENTER_A.
  - opa_q, opb_q, op_q, result_q = 0; result_valid, err_q, alu_start = 0.
  - timeout counter = 0; synchroniser flops = 1 (button released).
- Button path:
  - btn_enter passes through a 2-FF synchroniser and a falling-edge detector, producing a one-cycle press pulse.
  - The press acts on the 3rd rising clk edge after btn_enter is first sampled low.
  - Holding the button produces exactly one pulse.
- States and transitions (all transitions happen on a press unless noted):
  - ENTER_A: on press, opa_q <= sw_val, go to ENTER_OP.
  - ENTER_OP: on press, op_q <= sw_op. If sw_op is 1..5, go to ENTER_B; otherwise go to ERR with err_q <= 1.
  - ENTER_B: on press, opb_q <= sw_val. If op_q==3 and sw_val==0, go to ERR with err_q <= 1 and no ALU request is issued. Otherwise go to ISSUE.
  - ISSUE: alu_start=1 for exactly this one cycle; counter cleared; unconditional move to WAIT next cycle.
  - WAIT:
    - Counter increments each cycle.
    - On alu_done: result_q <= alu_result. If alu_err, set err_q and go to ERR; else set result_valid and go to SHOW.
    - If the counter reaches TIMEOUT without alu_done: err_q <= 1, go to ERR.
    - alu_done in the same cycle as timeout: alu_done wins.
  - SHOW / ERR: on press, clear result_valid, err_q and result_q to 0, then go to ENTER_A. opa_q, opb_q and op_q keep their values until overwritten.
- Presses in ISSUE or WAIT are discarded; they are not queued.
- alu_done outside WAIT is ignored.
- alu_opa, alu_opb and alu_op are stable from ISSUE through the alu_done cycle.
- Reset mid-WAIT aborts the operation. A later stray alu_done is ignored because the state is ENTER_A.
- phase encoding: ENTER_A=0, ENTER_OP=1, ENTER_B=2, ISSUE=3, WAIT=4, SHOW=5, ERR=6.
- Widths: result_q is 2*OPW wide, sized for the largest product (15*15=225 fits in 8 bits); no truncation.
- All outputs are registered except alu_opa, alu_opb and alu_op, which are direct register copies.

Decomposition:
- Package calc_pkg:
  - opcode enum (OP_ADD=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5).
  - state enum with the phase encoding above.
  - OPW default constant.
- Sub-module btn_edge: 2-FF synchroniser plus falling-edge pulse generator, with reset to the released state. It is reused for future keys.

Test Plan:
- Entry and add: press with sw_val=7; press with sw_op=1; press with sw_val=9 → alu_start pulses once with opa=7, op=1, opb=9. ALU model returns 16 after 3 cycles → result_q=16, result_valid=1, phase=5.
- Divide by zero: A=8, op=3, B=0 → phase=6 and err_q=1 with alu_start never asserted. Next press → phase=0, err_q=0.
- Invalid opcode: sw_op=6 at ENTER_OP → ERR immediately, op_q=6.
- Timeout: TIMEOUT=10, ALU model never responds → err_q=1 exactly 10 cycles after WAIT entry. alu_done at cycle 10 instead → result accepted, err_q=0.
- Button behaviour:
  - Hold btn_enter low for 50 cycles in ENTER_A → exactly one capture, phase=1.
  - Presses during WAIT (ALU latency 20) → ignored, still exactly one result.
- Reset mid-operation: assert ac during WAIT, release, then pulse alu_done → phase=0, result_valid=0, all outputs at reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-end sequencer.
package calc_pkg;

    localparam int OPW_DEF = 4;

    // Operator codes as set on the operator switches.
    typedef enum logic [2:0] {
        OP_ADD = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5
    } opcode_e;

    // Sequencer states; the encoding doubles as the phase LED value.
    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_OP = 3'd1,
        ST_ENTER_B  = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT     = 3'd4,
        ST_SHOW     = 3'd5,
        ST_ERR      = 3'd6
    } state_e;

    // True when the operator code selects an operation the ALU implements.
    function automatic logic op_is_valid(input logic [2:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_MUL, OP_DIV, OP_AND, OP_OR: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Synchronises an active-low pushbutton and emits a one-cycle pulse
// on each press (falling edge). Resets to the released state so that
// a button held through reset does not produce a spurious press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-stage synchroniser followed by a history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // High for the one cycle after the synchronised level falls.
    assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front-end: walks the user through operand A, operator and
// operand B entry with a single Enter key, hands the operation to the ALU
// over a start/done handshake and holds the result or error for display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             ac,
    input  logic [OPW-1:0]   sw_val,
    input  logic [2:0]       sw_op,
    input  logic             btn_enter,
    output logic             alu_start,
    output logic [OPW-1:0]   alu_opa,
    output logic [OPW-1:0]   alu_opb,
    output logic [2:0]       alu_op,
    input  logic             alu_done,
    input  logic [2*OPW-1:0] alu_result,
    input  logic             alu_err,
    output logic [OPW-1:0]   opa_q,
    output logic [OPW-1:0]   opb_q,
    output logic [2:0]       op_q,
    output logic [2*OPW-1:0] result_q,
    output logic             result_valid,
    output logic             err_q,
    output logic [2:0]       phase,
    output logic             busy
);

    // The wait counter gives up once it has counted TIMEOUT WAIT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       press_s;

    btn_edge u_enter (
        .clk     (clk),
        .rst     (ac),
        .btn_n_i (btn_enter),
        .press_o (press_s)
    );

    // Entry / issue / wait sequencing with all outputs held in registers.
    always_ff @(posedge clk or posedge ac) begin
        if (ac) begin
            state_q      <= ST_ENTER_A;
            cnt_q        <= 8'd0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= 3'd0;
            result_q     <= '0;
            result_valid <= 1'b0;
            err_q        <= 1'b0;
            alu_start    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state_q)
                ST_ENTER_A: begin
                    if (press_s) begin
                        opa_q   <= sw_val;
                        state_q <= ST_ENTER_OP;
                    end
                end
                ST_ENTER_OP: begin
                    if (press_s) begin
                        op_q <= sw_op;
                        if (op_is_valid(sw_op)) begin
                            state_q <= ST_ENTER_B;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_ENTER_B: begin
                    if (press_s) begin
                        opb_q <= sw_val;
                        // Divide by zero is caught here so the ALU never sees it.
                        if ((op_q == OP_DIV) && (sw_val == '0)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            alu_start <= 1'b1;
                            busy      <= 1'b1;
                            cnt_q     <= 8'd0;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= 8'd0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the final allowed cycle still counts.
                    if (alu_done) begin
                        result_q <= alu_result;
                        busy     <= 1'b0;
                        if (alu_err) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            result_valid <= 1'b1;
                            state_q      <= ST_SHOW;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_ERR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_SHOW, ST_ERR: begin
                    // Operands and opcode are kept so the next entry can overwrite them.
                    if (press_s) begin
                        result_valid <= 1'b0;
                        err_q        <= 1'b0;
                        result_q     <= '0;
                        state_q      <= ST_ENTER_A;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_ENTER_A;
                end
            endcase
        end
    end

    assign phase   = state_q;
    assign alu_opa = opa_q;
    assign alu_opb = opb_q;
    assign alu_op  = op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed, table-driven bench for calc_sequencer with a small ALU model.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       ac;
    logic [3:0] sw_val;
    logic [2:0] sw_op;
    logic       btn_enter;
    logic       alu_start;
    logic [3:0] alu_opa, alu_opb;
    logic [2:0] alu_op;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_err;
    logic [3:0] opa_q, opb_q;
    logic [2:0] op_q;
    logic [7:0] result_q;
    logic       result_valid, err_q, busy;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_mis = 0;

    // ALU model controls: latency 0 means the model never answers.
    int         alu_lat = 0;
    logic [7:0] alu_res = 8'd0;
    logic       alu_e   = 1'b0;
    bit         inject  = 1'b0;
    int         start_cnt = 0;
    bit         pending = 1'b0;
    int         cnt = 0;

    calc_sequencer #(.OPW(4), .TIMEOUT(10)) dut (
        .clk(clk), .ac(ac), .sw_val(sw_val), .sw_op(sw_op), .btn_enter(btn_enter),
        .alu_start(alu_start), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .opa_q(opa_q), .opb_q(opb_q), .op_q(op_q), .result_q(result_q),
        .result_valid(result_valid), .err_q(err_q), .phase(phase), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: answers alu_lat cycles after the start pulse, driven on negedge.
    always @(negedge clk) begin
        alu_done = 1'b0;
        if (ac) begin
            pending = 1'b0;
        end else begin
            if (inject) begin
                alu_done   = 1'b1;
                alu_result = 8'hA5;
                alu_err    = 1'b0;
                inject     = 1'b0;
            end
            if (pending) begin
                if (cnt <= 1) begin
                    alu_done   = 1'b1;
                    alu_result = alu_res;
                    alu_err    = alu_e;
                    pending    = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            if (alu_start) begin
                start_cnt = start_cnt + 1;
                if (alu_lat > 0) begin
                    pending = 1'b1;
                    cnt     = alu_lat;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press();
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        btn_enter = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_phase(input logic [2:0] p, input int bound, input string name);
        int i;
        i = 0;
        while ((phase !== p) && (i < bound)) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(phase), 32'(p));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [2:0] op;
        logic [3:0] b;
        bit         skip_b;
        int         lat;
        logic [7:0] res;
        logic       aerr;
        logic [2:0] e_phase;
        logic [7:0] e_res;
        logic       e_valid;
        logic       e_err;
        int         e_starts;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        vecs[0]  = '{4'd7,  3'd1, 4'd9,  1'b0, 3,  8'd16,  1'b0, 3'd5, 8'd16,  1'b1, 1'b0, 1};
        vecs[1]  = '{4'd15, 3'd2, 4'd15, 1'b0, 5,  8'd225, 1'b0, 3'd5, 8'd225, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'd8,  3'd3, 4'd0,  1'b0, 3,  8'd99,  1'b0, 3'd6, 8'd0,   1'b0, 1'b1, 0};
        vecs[3]  = '{4'd8,  3'd3, 4'd2,  1'b0, 4,  8'd4,   1'b0, 3'd5, 8'd4,   1'b1, 1'b0, 1};
        vecs[4]  = '{4'd12, 3'd4, 4'd10, 1'b0, 1,  8'd8,   1'b0, 3'd5, 8'd8,   1'b1, 1'b0, 1};
        vecs[5]  = '{4'd12, 3'd5, 4'd3,  1'b0, 2,  8'd15,  1'b0, 3'd5, 8'd15,  1'b1, 1'b0, 1};
        vecs[6]  = '{4'd5,  3'd6, 4'd1,  1'b1, 0,  8'd0,   1'b0, 3'd6, 8'd0,   1'b0, 1'b1, 0};
        vecs[7]  = '{4'd4,  3'd0, 4'd1,  1'b1, 0,  8'd0,   1'b0, 3'd6, 8'd0,   1'b0, 1'b1, 0};
        vecs[8]  = '{4'd3,  3'd2, 4'd4,  1'b0, 10, 8'd12,  1'b0, 3'd5, 8'd12,  1'b1, 1'b0, 1};
        vecs[9]  = '{4'd3,  3'd1, 4'd4,  1'b0, 0,  8'd0,   1'b0, 3'd6, 8'd0,   1'b0, 1'b1, 1};
        vecs[10] = '{4'd9,  3'd1, 4'd1,  1'b0, 2,  8'd10,  1'b1, 3'd6, 8'd10,  1'b0, 1'b1, 1};
        vecs[11] = '{4'd6,  3'd7, 4'd1,  1'b1, 0,  8'd0,   1'b0, 3'd6, 8'd0,   1'b0, 1'b1, 0};

        ac = 1'b1; btn_enter = 1'b1; sw_val = 4'd0; sw_op = 3'd0;
        alu_done = 1'b0; alu_result = 8'd0; alu_err = 1'b0;
        repeat (3) @(negedge clk);
        ac = 1'b0;
        @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_result", 32'(result_q), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_err", 32'(err_q), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_opa", 32'(opa_q), 32'd0);

        // Table-driven full transactions.
        for (int i = 0; i < 12; i++) begin
            alu_lat = vecs[i].lat; alu_res = vecs[i].res; alu_e = vecs[i].aerr;
            start_cnt = 0;
            sw_val = vecs[i].a;  press();
            sw_op  = vecs[i].op; press();
            if (!vecs[i].skip_b) begin
                sw_val = vecs[i].b; press();
            end
            wait_phase(vecs[i].e_phase, 200, $sformatf("v%0d_phase", i));
            check($sformatf("v%0d_result", i), 32'(result_q), 32'(vecs[i].e_res));
            check($sformatf("v%0d_valid", i), 32'(result_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_err", i), 32'(err_q), 32'(vecs[i].e_err));
            check($sformatf("v%0d_starts", i), 32'(start_cnt), 32'(vecs[i].e_starts));
            check($sformatf("v%0d_opa", i), 32'(alu_opa), 32'(vecs[i].a));
            check($sformatf("v%0d_op", i), 32'(alu_op), 32'(vecs[i].op));
            if (!vecs[i].skip_b)
                check($sformatf("v%0d_opb", i), 32'(alu_opb), 32'(vecs[i].b));
            press();
            check($sformatf("v%0d_clr_phase", i), 32'(phase), 32'd0);
            check($sformatf("v%0d_clr_err", i), 32'(err_q), 32'd0);
            check($sformatf("v%0d_clr_valid", i), 32'(result_valid), 32'd0);
            check($sformatf("v%0d_clr_result", i), 32'(result_q), 32'd0);
        end

        // Exact timeout: err_q rises 10 cycles after WAIT is entered.
        alu_lat = 0; start_cnt = 0;
        sw_val = 4'd2; press();
        sw_op = 3'd1;  press();
        sw_val = 4'd3;
        btn_enter = 1'b0;
        wait_phase(3'd4, 20, "to_enter_wait");
        n = 0;
        while (!err_q && n < 30) begin
            @(negedge clk);
            n++;
        end
        btn_enter = 1'b1;
        check("to_cycles", 32'(n), 32'd10);
        check("to_phase", 32'(phase), 32'd6);
        repeat (4) @(negedge clk);
        press();
        check("to_clr_phase", 32'(phase), 32'd0);

        // Holding Enter for 50 cycles captures operand A exactly once.
        sw_val = 4'd5;
        btn_enter = 1'b0;
        repeat (50) @(negedge clk);
        check("hold_phase", 32'(phase), 32'd1);
        check("hold_opa", 32'(opa_q), 32'd5);
        btn_enter = 1'b1;
        repeat (4) @(negedge clk);
        check("hold_release_phase", 32'(phase), 32'd1);

        // Presses during WAIT are dropped and not queued.
        alu_lat = 10; alu_res = 8'd30; alu_e = 1'b0; start_cnt = 0;
        sw_op = 3'd2;  press();
        sw_val = 4'd6; press();
        check("wp_phase_wait", 32'(phase), 32'd4);
        check("wp_busy", 32'(busy), 32'd1);
        press();
        wait_phase(3'd5, 30, "wp_phase_show");
        check("wp_result", 32'(result_q), 32'd30);
        check("wp_starts", 32'(start_cnt), 32'd1);
        check("wp_busy_after", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("wp_no_queue", 32'(phase), 32'd5);
        press();
        check("wp_clr_phase", 32'(phase), 32'd0);

        // Reset in WAIT aborts; a late alu_done is ignored.
        alu_lat = 0;
        sw_val = 4'd7; press();
        sw_op = 3'd1;  press();
        sw_val = 4'd1;
        btn_enter = 1'b0;
        wait_phase(3'd4, 20, "rw_enter_wait");
        ac = 1'b1;
        btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        ac = 1'b0;
        inject = 1'b1;
        repeat (3) @(negedge clk);
        check("rw_phase", 32'(phase), 32'd0);
        check("rw_valid", 32'(result_valid), 32'd0);
        check("rw_err", 32'(err_q), 32'd0);
        check("rw_result", 32'(result_q), 32'd0);
        check("rw_opa", 32'(opa_q), 32'd0);
        check("rw_opb", 32'(opb_q), 32'd0);
        check("rw_op", 32'(op_q), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_start", 32'(alu_start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
